ws_array_dbuf: RTL and testbench
================================

# ws_array_dbuf

Weight-stationary systolic matrix-multiply engine with double-buffered weights, internal input skew/output deskew and valid/ready handshakes. It computes out = a · B for a stream of ROWS-element activation vectors against a ROWS×COLS weight matrix B, returning one COLS-element result vector per accepted input. It sits between the activation/weight buffers and the accumulator/post-processing stage. It replaces the bare MAC array with a self-timed unit that reloads weights in the background and supports signed and unsigned operands.

## Interface
- ROWS, 16: reduction depth K (activation vector length, rows of B)
- COLS, 16: output width N (columns of B)
- WIDTH, 8: operand width
- ACC_WIDTH, 2*WIDTH+$clog2(ROWS): accumulator/result element width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- w_valid  in  1  weight row beat valid
- w_ready  out  1  shadow bank can accept a row
- w_data  in  COLS*WIDTH  row k of B; element n at [n*WIDTH +: WIDTH]
- w_signed  in  1  operand mode; sampled on the final (k=ROWS-1) weight beat
- a_valid  in  1  activation vector valid
- a_ready  out  1  array can accept a vector
- a_data  in  ROWS*WIDTH  activation vector; element k at [k*WIDTH +: WIDTH]
- out_valid  out  1  result vector valid (one-cycle pulse per vector)
- out_data  out  COLS*ACC_WIDTH  result; element n at [n*ACC_WIDTH +: ACC_WIDTH]
- active_valid  out  1  an active weight bank is loaded

## Operation
- Two weight banks (ROWS×COLS×WIDTH each) plus a mode bit per bank. One bank is active and feeds the PEs; the other is the shadow.
- Weight load: each w_valid&&w_ready beat writes shadow row row_cnt, then increments row_cnt. After beat ROWS-1:
  - row_cnt wraps to 0;
  - the shadow mode bit takes w_signed;
  - swap_pending is set.
- w_ready = !swap_pending.
- Swap: in the cycle where swap_pending && inflight==0, the active/shadow select toggles, active_valid goes 1 and swap_pending clears. The same swap fires if no bank was loaded before.
- a_ready = active_valid && !swap_pending. Vectors already in flight complete with the old weights. No vector ever mixes banks.
- Compute: out_data[n] = Σ_k a[k]·B[k][n].
  - Signed mode: both operands are two's complement and sign-extended to ACC_WIDTH.
  - Unsigned mode: both operands are zero-extended.
  - Sums wrap modulo 2^ACC_WIDTH; the default ACC_WIDTH cannot overflow.
- Datapath: a_data is registered on acceptance. Row k is delayed k cycles (skew). Activations move one PE right per cycle and partial sums move one PE down per cycle. Column n output is delayed COLS-1-n cycles (deskew), so all elements of a vector emerge together.
- inflight counter (0..LAT): +1 on accept, -1 on out_valid; both in the same cycle leaves it unchanged.
- No output backpressure. The consumer must take out_data whenever out_valid=1.
- The mode bit travels with the bank: a vector uses the mode of the bank that was active when it was accepted.

## Timing
- Reset values:
  - w_ready=1 (drops only while swap_pending), a_ready=0, out_valid=0, out_data=0, active_valid=0.
  - row_cnt=0, inflight=0, swap_pending=0, bank select=0.
  - All pipeline, skew and weight registers are 0.
- Latency LAT = ROWS+COLS+1 cycles: a vector accepted at edge t gives out_valid=1 at edge t+LAT. Default LAT=33.
- Throughput: one vector per cycle when a_valid is held and no swap is pending. Gaps in a_valid propagate as out_valid gaps.
- After the final weight beat at edge t, with an idle array, the swap occurs at edge t+1. a_ready can be 1 from t+1 onward, and w_ready returns to 1 in the same cycle.
- If vectors are in flight, the swap occurs the cycle after the last out_valid pulse.
- If a weight beat and an activation accept occur in the same cycle, both are legal; the beat writes only the shadow bank.
- Reset mid-operation clears everything immediately:
  - in-flight results are discarded and no out_valid is produced;
  - both banks become invalid and a partial weight load is lost (row_cnt=0).

## Test plan
- ROWS=COLS=4, WIDTH=8, unsigned identity B, a=[1,2,3,4] accepted at edge t -> out_valid at t+9, out_data=[1,2,3,4].
- B all 0xFF, a=[1,1,1,1]:
  - signed mode -> every element = -4 (18-bit 0x3FFFC);
  - unsigned mode -> every element = 1020.
- Unsigned, all operands 0xFF -> every element 260100 (no wrap). Stream 20 back-to-back random vectors -> 20 consecutive out_valid pulses, each matching the reference model.
- Load bank 1 while streaming on bank 0 -> w_ready=0 after 4 beats, a_ready drops and the array drains. The swap happens the cycle after the last bank-0 result; subsequent results use bank 1, and none mixes banks.
- Before any weights are loaded: a_ready=0 and a_valid is ignored. After the first 4-beat load -> active_valid=1 the next cycle.
- Assert rst_n mid-stream and mid-weight-load -> all outputs take reset values the same cycle and no stale out_valid appears. Reloading weights -> correct results.

Source files
------------

// File: rtl/ws_array_dbuf.sv
// ws_array_dbuf
//   Weight-stationary systolic matrix-multiply engine: out = a * B for a
//   stream of ROWS-element activation vectors against a ROWS x COLS weight
//   matrix. Weights are double-buffered; the shadow bank is loaded row by row
//   in the background and swapped in once the array has drained.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   w_valid/w_ready       weight row beat handshake (row k of B per beat)
//   w_data                row of B, element n at [n*WIDTH +: WIDTH]
//   w_signed              operand mode, sampled on the final weight beat
//   a_valid/a_ready       activation vector handshake
//   a_data                activation vector, element k at [k*WIDTH +: WIDTH]
//   out_valid             one-cycle pulse per result vector (no backpressure)
//   out_data              result, element n at [n*ACC_WIDTH +: ACC_WIDTH]
//   active_valid          an active weight bank is loaded
module ws_array_dbuf #(
   parameter int ROWS      = 16,
   parameter int COLS      = 16,
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH + $clog2(ROWS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [COLS*WIDTH-1:0]     w_data,
   input  logic                      w_signed,
   input  logic                      a_valid,
   output logic                      a_ready,
   input  logic [ROWS*WIDTH-1:0]     a_data,
   output logic                      out_valid,
   output logic [COLS*ACC_WIDTH-1:0] out_data,
   output logic                      active_valid
);

   localparam int LAT = ROWS + COLS + 1;
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW  = $clog2(LAT + 2);
   localparam int XW  = WIDTH + 1;          // operand after sign/zero extension
   localparam int PW  = 2 * XW;             // product width

   // One extra bit lets signed and unsigned operands share a signed multiplier.
   function automatic logic [XW-1:0] sx(input logic [WIDTH-1:0] v, input logic sgn);
      return {sgn & v[WIDTH-1], v};
   endfunction

   // ------------------------------------------------------------------
   // Control: weight load counter, bank select, swap and in-flight count
   // ------------------------------------------------------------------
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic          sel_q, sel_d;
   logic          swap_pend_q, swap_pend_d;
   logic          act_vld_q, act_vld_d;
   logic [1:0]    mode_q, mode_d;
   logic          out_valid_q;
   logic          w_fire, a_fire, last_beat, do_swap;

   assign w_ready   = !swap_pend_q;
   assign a_ready   = act_vld_q && !swap_pend_q;
   assign w_fire    = w_valid && w_ready;
   assign a_fire    = a_valid && a_ready;
   assign last_beat = w_fire && (row_cnt_q == RW'(ROWS - 1));
   // a_ready is low while a swap is pending, so nothing new enters before it.
   assign do_swap   = swap_pend_q && (inflight_q == '0);

   always_comb begin
      row_cnt_d   = row_cnt_q;
      swap_pend_d = swap_pend_q;
      sel_d       = sel_q;
      act_vld_d   = act_vld_q;
      mode_d      = mode_q;
      inflight_d  = inflight_q;
      if (w_fire) begin
         row_cnt_d = last_beat ? '0 : row_cnt_q + 1'b1;
      end
      if (last_beat) begin
         mode_d[~sel_q] = w_signed;
         swap_pend_d    = 1'b1;
      end
      if (do_swap) begin
         sel_d       = ~sel_q;
         act_vld_d   = 1'b1;
         swap_pend_d = 1'b0;
      end
      case ({a_fire, out_valid_q})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt_q   <= '0;
         inflight_q  <= '0;
         sel_q       <= 1'b0;
         swap_pend_q <= 1'b0;
         act_vld_q   <= 1'b0;
         mode_q      <= '0;
      end else begin
         row_cnt_q   <= row_cnt_d;
         inflight_q  <= inflight_d;
         sel_q       <= sel_d;
         swap_pend_q <= swap_pend_d;
         act_vld_q   <= act_vld_d;
         mode_q      <= mode_d;
      end
   end

   // ------------------------------------------------------------------
   // Weight banks: beats only ever write the shadow bank
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] wbank_q [2][ROWS][COLS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned k = 0; k < ROWS; k++) begin
               for (int unsigned n = 0; n < COLS; n++) begin
                  wbank_q[b][k][n] <= '0;
               end
            end
         end
      end else if (w_fire) begin
         for (int unsigned n = 0; n < COLS; n++) begin
            wbank_q[~sel_q][row_cnt_q][n] <= w_data[n*WIDTH +: WIDTH];
         end
      end
   end

   // ------------------------------------------------------------------
   // Input register, operand extension, valid pipeline, output register
   // ------------------------------------------------------------------
   logic [WIDTH-1:0]          a_q     [ROWS];
   logic [XW-1:0]             ext_q   [ROWS];
   logic [LAT-1:0]            vld_q;
   logic [COLS*ACC_WIDTH-1:0] out_data_q;
   logic [ACC_WIDTH-1:0]      dsk_w   [COLS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < ROWS; k++) begin
            a_q[k]   <= '0;
            ext_q[k] <= '0;
         end
         vld_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (a_fire) begin
            for (int unsigned k = 0; k < ROWS; k++) begin
               a_q[k] <= a_data[k*WIDTH +: WIDTH];
            end
         end
         // Bank cannot change while a vector is in flight, so the active
         // mode here is the mode the vector was accepted under.
         for (int unsigned k = 0; k < ROWS; k++) begin
            ext_q[k] <= sx(a_q[k], mode_q[sel_q]);
         end
         vld_q       <= {vld_q[LAT-2:0], a_fire};
         out_valid_q <= vld_q[LAT-1];
         if (vld_q[LAT-1]) begin
            for (int unsigned n = 0; n < COLS; n++) begin
               out_data_q[n*ACC_WIDTH +: ACC_WIDTH] <= dsk_w[n];
            end
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign active_valid = act_vld_q;

   // ------------------------------------------------------------------
   // Input skew: row k delayed k cycles
   // ------------------------------------------------------------------
   logic [XW-1:0] act_in [ROWS];

   for (genvar k = 0; k < ROWS; k++) begin : g_skew
      if (k == 0) begin : g_direct
         assign act_in[k] = ext_q[k];
      end else begin : g_dly
         localparam int unsigned DEPTH = k;
         logic [XW-1:0] sk_q [DEPTH];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  sk_q[i] <= '0;
               end
            end else begin
               sk_q[0] <= ext_q[k];
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  sk_q[i] <= sk_q[i-1];
               end
            end
         end
         assign act_in[k] = sk_q[DEPTH-1];
      end
   end

   // ------------------------------------------------------------------
   // PE array: act_w/ps_w are the activation/partial-sum inputs of each PE
   // ------------------------------------------------------------------
   logic [XW-1:0]        act_w [ROWS][COLS];
   logic [ACC_WIDTH-1:0] ps_w  [ROWS][COLS];
   logic [ACC_WIDTH-1:0] bot_w [COLS];

   for (genvar n = 0; n < COLS; n++) begin : g_top
      assign ps_w[0][n] = '0;
   end

   for (genvar k = 0; k < ROWS; k++) begin : g_row
      assign act_w[k][0] = act_in[k];
      for (genvar n = 0; n < COLS; n++) begin : g_col
         logic signed [PW-1:0] prod;
         logic [ACC_WIDTH-1:0] sum_q;

         assign prod = signed'(act_w[k][n]) * signed'(sx(wbank_q[sel_q][k][n], mode_q[sel_q]));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum_q <= '0;
            end else begin
               sum_q <= ps_w[k][n] + ACC_WIDTH'(prod);
            end
         end

         if (k < ROWS - 1) begin : g_down
            assign ps_w[k+1][n] = sum_q;
         end else begin : g_bot
            assign bot_w[n] = sum_q;
         end

         if (n < COLS - 1) begin : g_fwd
            logic [XW-1:0] act_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  act_q <= '0;
               end else begin
                  act_q <= act_w[k][n];
               end
            end
            assign act_w[k][n+1] = act_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output deskew: column n delayed COLS-1-n cycles
   // ------------------------------------------------------------------
   for (genvar n = 0; n < COLS; n++) begin : g_dsk
      localparam int unsigned DEPTH = COLS - 1 - n;
      if (DEPTH == 0) begin : g_direct
         assign dsk_w[n] = bot_w[n];
      end else begin : g_dly
         logic [ACC_WIDTH-1:0] dk_q [DEPTH];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  dk_q[i] <= '0;
               end
            end else begin
               dk_q[0] <= bot_w[n];
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  dk_q[i] <= dk_q[i-1];
               end
            end
         end
         assign dsk_w[n] = dk_q[DEPTH-1];
      end
   end

endmodule

// File: tb/tb_ws_array_dbuf.sv
// tb_ws_array_dbuf
//   Directed bench for ws_array_dbuf with ROWS=COLS=4, WIDTH=8, ACC_WIDTH=18.
//   Expected result vectors are queued on acceptance and compared, along
//   with the acceptance-to-output latency, whenever out_valid is seen.
module tb_ws_array_dbuf;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int WIDTH = 8;
   localparam int ACC = 18;
   localparam int LAT = ROWS + COLS + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [31:0] w_data = '0;
   logic        w_signed = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [31:0] a_data = '0;
   logic        out_valid;
   logic [71:0] out_data;
   logic        active_valid;

   ws_array_dbuf #(
      .ROWS(ROWS),
      .COLS(COLS),
      .WIDTH(WIDTH),
      .ACC_WIDTH(ACC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .w_valid(w_valid),
      .w_ready(w_ready),
      .w_data(w_data),
      .w_signed(w_signed),
      .a_valid(a_valid),
      .a_ready(a_ready),
      .a_data(a_data),
      .out_valid(out_valid),
      .out_data(out_data),
      .active_valid(active_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   logic [71:0] exp_q[$];
   int          acc_q[$];
   int          n_out = 0;
   int          last_out = -1;

   logic [31:0] bm [4];
   logic        bm_sgn = 1'b0;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: out[n] = sum_k a[k]*B[k][n], modulo 2^18
   function automatic logic [71:0] model(input logic [31:0] a, input logic [31:0] b [4], input logic sgn);
      logic [71:0] r;
      r = '0;
      for (int n = 0; n < 4; n++) begin
         int s;
         s = 0;
         for (int k = 0; k < 4; k++) begin
            logic [7:0] x, y;
            int xv, yv;
            x = a[k*8 +: 8];
            y = b[k][n*8 +: 8];
            xv = sgn ? int'($signed(x)) : int'(x);
            yv = sgn ? int'($signed(y)) : int'(y);
            s += xv * yv;
         end
         r[n*18 +: 18] = s[17:0];
      end
      return r;
   endfunction

   // Output monitor
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         n_out++;
         last_out = cyc;
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 72'(out_valid), 72'd0);
         end else begin
            logic [71:0] e;
            int t;
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            chk("out_data", out_data, e);
            chk("latency", 72'(cyc), 72'(t + LAT));
         end
      end
   end

   // One cycle of stimulus, applied at a negedge; returns handshake outcomes.
   task automatic step(input logic av, input logic [31:0] ad, input logic [71:0] ae,
                       input logic wv, input logic [31:0] wd, input logic ws,
                       output logic acc, output logic wf);
      a_valid  = av;
      a_data   = ad;
      w_valid  = wv;
      w_data   = wd;
      w_signed = ws;
      acc = av && a_ready;
      wf  = wv && w_ready;
      if (acc) begin
         exp_q.push_back(ae);
         acc_q.push_back(cyc + 1);
      end
      @(negedge clk);
   endtask

   task automatic load(input logic [31:0] rows [4], input logic sgn);
      int k;
      int guard;
      logic acc, wf;
      k = 0;
      guard = 0;
      while (k < 4 && guard < 40) begin
         step(1'b0, '0, '0, 1'b1, rows[k], sgn, acc, wf);
         if (wf) k++;
         guard++;
      end
      w_valid = 1'b0;
      chk("load_beats", 72'(k), 72'd4);
      bm = rows;
      bm_sgn = sgn;
   endtask

   task automatic send(input logic [31:0] a, input logic [71:0] e);
      logic acc, wf;
      int guard;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 40) begin
         step(1'b1, a, e, 1'b0, '0, 1'b0, acc, wf);
         guard++;
      end
      a_valid = 1'b0;
      chk("send_accepted", 72'(acc), 72'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", 72'(exp_q.size()), 72'd0);
      @(negedge clk);
   endtask

   logic [31:0] ident [4] = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
   logic [31:0] allff [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] dbl   [4] = '{32'h00000002, 32'h00000200, 32'h00020000, 32'h02000000};
   logic [31:0] ramp  [4] = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
   logic [31:0] rnd   [4];

   initial begin
      logic acc, wf;
      int cnt, k, t_sw, n0;
      logic [31:0] a;

      // Reset state
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_w_ready", 72'(w_ready), 72'd1);
      chk("rst_a_ready", 72'(a_ready), 72'd0);
      chk("rst_out_valid", 72'(out_valid), 72'd0);
      chk("rst_out_data", out_data, 72'd0);
      chk("rst_active_valid", 72'(active_valid), 72'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // No bank loaded: activations ignored
      for (int i = 0; i < 3; i++) step(1'b1, 32'h04030201, '0, 1'b0, '0, 1'b0, acc, wf);
      a_valid = 1'b0;
      chk("unloaded_a_ready", 72'(a_ready), 72'd0);

      // First load: swap one cycle after the final beat
      load(ident, 1'b0);
      chk("pend_w_ready", 72'(w_ready), 72'd0);
      chk("pend_active_valid", 72'(active_valid), 72'd0);
      chk("pend_a_ready", 72'(a_ready), 72'd0);
      @(negedge clk);
      chk("swap_active_valid", 72'(active_valid), 72'd1);
      chk("swap_w_ready", 72'(w_ready), 72'd1);
      chk("swap_a_ready", 72'(a_ready), 72'd1);

      send(32'h04030201, {18'd4, 18'd3, 18'd2, 18'd1});
      drain();

      // Signed all-ones weights
      load(allff, 1'b1);
      @(negedge clk);
      send(32'h01010101, {4{18'h3FFFC}});
      drain();

      // Unsigned all-ones weights
      load(allff, 1'b0);
      @(negedge clk);
      send(32'h01010101, {4{18'd1020}});
      send(32'hFFFFFFFF, {4{18'd260100}});
      drain();

      // Random signed matrix, 20 back-to-back vectors
      for (int i = 0; i < 4; i++) rnd[i] = $urandom;
      load(rnd, 1'b1);
      @(negedge clk);
      n0 = n_out;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         step(1'b1, a, model(a, bm, bm_sgn), 1'b0, '0, 1'b0, acc, wf);
         if (acc) cnt++;
      end
      a_valid = 1'b0;
      chk("stream_accepts", 72'(cnt), 72'd20);
      drain();
      chk("stream_outputs", 72'(n_out - n0), 72'd20);

      // Background load of the other bank while streaming on the active one
      k = 0;
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         step(1'b1, a, model(a, bm, bm_sgn), (i >= 2), dbl[k], 1'b0, acc, wf);
         if (wf) k++;
      end
      chk("bg_beats", 72'(k), 72'd4);
      bm = dbl;
      bm_sgn = 1'b0;
      a_valid = 1'b0;
      w_valid = 1'b0;
      chk("bg_w_ready", 72'(w_ready), 72'd0);
      chk("bg_a_ready", 72'(a_ready), 72'd0);
      t_sw = -1;
      for (int j = 0; j < 40; j++) begin
         if (a_ready) begin
            t_sw = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("bg_swap_cycle", 72'(t_sw), 72'(last_out + 2));
      chk("bg_drained", 72'(exp_q.size()), 72'd0);
      send(32'h08070605, {18'd16, 18'd14, 18'd12, 18'd10});
      send(32'hFFFFFFFF, {4{18'd510}});
      drain();

      // Reset in the middle of a stream and a weight load
      k = 0;
      for (int i = 0; i < 5; i++) begin
         a = $urandom;
         step(1'b1, a, model(a, bm, bm_sgn), (i >= 3), ramp[k], 1'b0, acc, wf);
         if (wf) k++;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 72'(out_valid), 72'd0);
      chk("mid_rst_out_data", out_data, 72'd0);
      chk("mid_rst_a_ready", 72'(a_ready), 72'd0);
      chk("mid_rst_w_ready", 72'(w_ready), 72'd1);
      chk("mid_rst_active_valid", 72'(active_valid), 72'd0);
      exp_q.delete();
      acc_q.delete();
      a_valid = 1'b0;
      w_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = n_out;
      for (int i = 0; i < 15; i++) @(negedge clk);
      chk("post_rst_quiet", 72'(n_out - n0), 72'd0);
      chk("post_rst_a_ready", 72'(a_ready), 72'd0);

      load(ramp, 1'b0);
      @(negedge clk);
      send(32'h01010101, {4{18'd10}});
      send(32'h04030201, {4{18'd30}});
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
